// File: rtl/parity_tx_arb_pkg.sv
// Shared types and constants for the arbitrated
// even-parity nibble transmitter.
package parity_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } state_t;

  localparam int FRAME_BITS = 7;
  localparam int DATA_BITS  = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Round-robin pick: a lone valid wins, a tie goes
  // to the requester that was not granted last.
  function automatic logic [1:0] rr_grant(
    input logic v0,
    input logic v1,
    input logic last
  );
    logic [1:0] g;
    g[0] = v0 && (!v1 || last);
    g[1] = v1 && (!v0 || !last);
    return g;
  endfunction

endpackage

// File: rtl/parity_tx_arb_even_parity.sv
// Even parity over the captured nibble.
// Purely combinational.
module even_parity
  import parity_tx_arb_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_tx_arb.sv
// Two-requester round-robin arbiter feeding a serial
// framer: start, 4 data bits LSB first, even parity, stop.
module parity_tx_arb
  import parity_tx_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_src,
  output logic                 frame_done
);

  localparam logic [3:0] GAP_LAST =
    4'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);

  state_t               state;
  state_t               state_d;
  logic [1:0]           bit_cnt;
  logic [3:0]           gap_cnt;
  logic [DATA_BITS-1:0] hold;
  logic                 last_grant;
  logic                 parity;
  logic                 tx_bit;
  logic [1:0]           grant;
  logic                 idle;

  even_parity u_par (
    .data   (hold),
    .parity (parity)
  );

  assign idle  = (state == ST_IDLE);
  assign grant = rr_grant(req0_valid, req1_valid,
                          last_grant);

  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:
        if (req0_ready || req1_ready)
          state_d = ST_START;
      ST_START:
        state_d = ST_DATA;
      ST_DATA:
        if (bit_cnt == 2'd3)
          state_d = ST_PARITY;
      ST_PARITY:
        state_d = ST_STOP;
      ST_STOP:
        state_d = (GAP_CYCLES > 0) ? ST_GAP
                                   : ST_IDLE;
      ST_GAP:
        if (gap_cnt == GAP_LAST)
          state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Line level is registered from the current state,
  // so each bit appears one edge after its state.
  always_comb begin
    tx_bit = STOP_BIT;
    unique case (state)
      ST_START:  tx_bit = START_BIT;
      ST_DATA:   tx_bit = hold[bit_cnt];
      ST_PARITY: tx_bit = parity;
      default:   tx_bit = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      hold       <= '0;
      last_grant <= 1'b1;
      tx_src     <= 1'b0;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= (state == ST_DATA)
                    ? bit_cnt + 2'd1 : 2'd0;
      gap_cnt    <= (state == ST_GAP)
                    ? gap_cnt + 4'd1 : 4'd0;
      tx_out     <= tx_bit;
      tx_busy    <= !idle;
      frame_done <= (state == ST_STOP);
      if (req0_ready) begin
        hold       <= req0_data;
        tx_src     <= 1'b0;
        last_grant <= 1'b0;
      end else if (req1_ready) begin
        hold       <= req1_data;
        tx_src     <= 1'b1;
        last_grant <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_tx_arb.sv
// Bench for parity_tx_arb: two instances (gap 1 and
// gap 0) checked against a frame-level model.
module tb_parity_tx_arb;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] v0, v1;
  logic [3:0] d0 [2];
  logic [3:0] d1 [2];
  logic [1:0] r0, r1, txo, busy, src, done;

  always #5 clk = ~clk;

  parity_tx_arb #(.GAP_CYCLES(1)) dut_g1 (
    .clk(clk), .rst(rst[0]),
    .req0_valid(v0[0]), .req0_data(d0[0]),
    .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]),
    .req1_ready(r1[0]),
    .tx_out(txo[0]), .tx_busy(busy[0]),
    .tx_src(src[0]), .frame_done(done[0])
  );

  parity_tx_arb #(.GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst[1]),
    .req0_valid(v0[1]), .req0_data(d0[1]),
    .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]),
    .req1_ready(r1[1]),
    .tx_out(txo[1]), .tx_busy(busy[1]),
    .tx_src(src[1]), .frame_done(done[1])
  );

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: ph = edges since handshake, -1 when idle.
  int   ph [2];
  logic ml [2];
  logic ms [2];
  logic mo [2];
  logic mb [2];
  logic md [2];
  logic fb [2][7];

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      ph[i] = -1; ml[i] = 1'b1; ms[i] = 1'b0;
      mo[i] = 1'b1; mb[i] = 1'b0; md[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        logic h0, h1;
        logic [3:0] nd;
        if (rst[i]) begin
          ph[i] = -1; ml[i] = 1'b1; ms[i] = 1'b0;
          mo[i] = 1'b1; mb[i] = 1'b0; md[i] = 1'b0;
        end else if (ph[i] < 0) begin
          mo[i] = 1'b1; mb[i] = 1'b0; md[i] = 1'b0;
          h0 = v0[i] && (!v1[i] || ml[i]);
          h1 = v1[i] && (!v0[i] || !ml[i]);
          if (h0 || h1) begin
            nd = h0 ? d0[i] : d1[i];
            ms[i] = h1; ml[i] = h1; ph[i] = 0;
            fb[i][0] = 1'b0;
            for (int k = 0; k < 4; k++)
              fb[i][1+k] = nd[k];
            fb[i][5] = nd[0] ^ nd[1] ^ nd[2] ^ nd[3];
            fb[i][6] = 1'b1;
          end
        end else begin
          ph[i]++;
          mo[i] = (ph[i] <= 7) ? fb[i][ph[i]-1] : 1'b1;
          md[i] = (ph[i] == 7);
          mb[i] = 1'b1;
          if (ph[i] == 7 + gap_of(i)) ph[i] = -1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          logic e0, e1, id;
          id = (ph[i] < 0) && !rst[i];
          e0 = id && v0[i] && (!v1[i] || ml[i]);
          e1 = id && v1[i] && (!v0[i] || !ml[i]);
          chk($sformatf("tx_out%0d", i), txo[i], mo[i]);
          chk($sformatf("busy%0d", i), busy[i], mb[i]);
          chk($sformatf("done%0d", i), done[i], md[i]);
          chk($sformatf("src%0d", i), src[i], ms[i]);
          if (!rst[i]) begin
            chk($sformatf("rdy0_%0d", i), r0[i], e0);
            chk($sformatf("rdy1_%0d", i), r1[i], e1);
          end
          chk($sformatf("excl%0d", i), r0[i] & r1[i], 0);
        end
      end
    end
  end

  task automatic send(input int i, input bit who,
                      input logic [3:0] data,
                      output logic [6:0] seq,
                      output logic dn);
    int t;
    logic [3:0] nd;
    nd = ~data;
    if (!who) begin v0[i] = 1'b1; d0[i] = data; end
    else begin v1[i] = 1'b1; d1[i] = data; end
    #1;
    t = 0;
    while (!(who ? r1[i] : r0[i]) && t < 30) begin
      step();
      t++;
    end
    chk("hs_wait", t < 30, 1);
    step();
    if (!who) begin v0[i] = 1'b0; d0[i] = nd; end
    else begin v1[i] = 1'b0; d1[i] = nd; end
    dn = 1'b0;
    seq = '0;
    for (int j = 0; j < 7; j++) begin
      step();
      seq[6-j] = txo[i];
      if (j == 6) dn = done[i];
    end
  endtask

  task automatic both(input int i, input int per,
                      input int n);
    int   last_t;
    int   frames;
    logic prev;
    last_t = -1;
    frames = 0;
    prev   = 1'b0;
    v0[i] = 1'b1;
    v1[i] = 1'b1;
    for (int c = 0; c < n; c++) begin
      d0[i] = 4'($urandom);
      d1[i] = 4'($urandom);
      step();
      if (done[i]) begin
        if (last_t >= 0) begin
          chk("period", cyc - last_t, per);
          chk("alt", src[i], !prev);
        end
        last_t = cyc;
        prev   = src[i];
        frames++;
      end
    end
    v0[i] = 1'b0;
    v1[i] = 1'b0;
    chk("frames", frames >= 4, 1);
    repeat (12) step();
  endtask

  logic [6:0] seq;
  logic       dn;

  initial begin
    rst = 2'b11;
    v0  = 2'b00;
    v1  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      d0[i] = '0;
      d1[i] = '0;
    end
    repeat (2) step();
    chk_en = 1'b1;
    chk("rst_out", txo, 2'b11);
    chk("rst_busy", busy, 2'b00);
    chk("rst_src", src, 2'b00);
    rst = 2'b00;
    step();

    send(0, 1'b0, 4'b1011, seq, dn);
    chk("f1011", seq, 7'b0110111);
    chk("done1011", dn, 1);
    chk("src1011", src[0], 0);

    send(0, 1'b1, 4'b1100, seq, dn);
    chk("f1100", seq, 7'b0001101);
    chk("par1100", seq[1], 0);
    chk("src1100", src[0], 1);
    repeat (4) step();

    for (int n = 0; n < 16; n++) begin
      send(0, 1'b0, 4'(n), seq, dn);
      chk("even", ^seq[5:1], 0);
      chk("nib", {seq[2], seq[3], seq[4], seq[5]}, n);
      chk("ndone", dn, 1);
    end
    repeat (4) step();

    v0[1] = 1'b1;
    d0[1] = 4'b0110;
    #1;
    for (int t = 0; t < 30 && !r0[1]; t++) step();
    step();
    v0[1] = 1'b0;
    repeat (4) step();
    chk("mid_d2", txo[1], 1);
    rst[1] = 1'b1;
    step();
    chk("mid_busy", busy[1], 0);
    chk("mid_out", txo[1], 1);
    chk("mid_done", done[1], 0);
    rst[1] = 1'b0;
    send(1, 1'b0, 4'b0110, seq, dn);
    chk("f0110", seq, 7'b0011001);
    chk("done0110", dn, 1);
    repeat (4) step();

    both(0, 9, 50);
    both(1, 8, 50);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        v0[i]  = ($urandom_range(0, 2) != 0);
        v1[i]  = ($urandom_range(0, 2) != 0);
        d0[i]  = 4'($urandom);
        d1[i]  = 4'($urandom);
        rst[i] = ($urandom_range(0, 59) == 0);
      end
      step();
    end
    rst = 2'b00;
    v0  = 2'b00;
    v1  = 2'b00;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/parity_tx_arb.md
PARITY_TX_ARB -- requirements
Module: parity_tx_arb

Interface
REQ-001 Parameter: GAP_CYCLES, 1, number of idle-high cycles inserted after each stop bit (legal range 0..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has a nibble to send.
REQ-005 req0_data  input  4  requester 0 nibble.
REQ-006 req0_ready  output  1  requester 0 nibble is accepted this cycle if req0_valid.
REQ-007 req1_valid  input  1  requester 1 has a nibble to send.
REQ-008 req1_data  input  4  requester 1 nibble.
REQ-009 req1_ready  output  1  requester 1 nibble is accepted this cycle if req1_valid.
REQ-010 tx_out  output  1  serial line, idle high.
REQ-011 tx_busy  output  1  high in every state except IDLE.
REQ-012 tx_src  output  1  index of the requester whose frame is on the line; holds its last value in IDLE.
REQ-013 frame_done  output  1  one-cycle pulse during the stop-bit cycle.

Function
REQ-014 Frame: 7 bits, 1 bit per clk: start(0), data[0], data[1], data[2], data[3], even-parity bit, stop(1).
REQ-015 Parity bit: XOR of the 4 captured data bits; data bits plus parity always contain an even number of ones.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
REQ-017 IDLE -> START on handshake; START -> DATA; DATA -> PARITY after 4 cycles (2-bit bit counter 0..3); PARITY -> STOP; STOP -> GAP if GAP_CYCLES>0, otherwise -> IDLE; GAP -> IDLE after GAP_CYCLES cycles.
REQ-018 Ready: reqN_ready = (state==IDLE) && (grant==N); both readies are 0 outside IDLE; at most one ready is high in any cycle.
REQ-019 Grant in IDLE, round-robin: if only one valid, grant that one; if both valid, grant the requester other than last_grant; if neither, no ready is asserted.
REQ-020 Handshake on valid && ready: capture the data into a 4-bit holding register, set tx_src and last_grant to N, and enter START on the next edge.
REQ-021 Latency: handshake at edge N -> start bit at N+1, data[0..3] at N+2..N+5, parity at N+6, stop plus frame_done at N+7.
REQ-022 Throughput: with GAP_CYCLES=g, the next handshake occurs no earlier than the IDLE cycle following cycle N+7+g.
REQ-023 tx_out = 1 in IDLE, STOP and GAP.
REQ-024 Requester data changes after the handshake shall not affect the frame in flight.
REQ-025 A deasserted valid in IDLE shall not be accepted, even if it was high in an earlier cycle.

Reset
REQ-026 rst overrides all other inputs at the clock edge, including mid-frame; the frame is abandoned with no frame_done pulse.
REQ-027 Reset values: state=IDLE, tx_out=1, tx_busy=0, frame_done=0, tx_src=0, last_grant=1 (requester 0 wins the first tie), bit counter=0, gap counter=0, holding register=0.
REQ-028 The readies may assert in the first cycle after rst deasserts.

Structure
REQ-029 Shared package: FSM state enumeration, FRAME_BITS=7, DATA_BITS=4, START_BIT=0 and STOP_BIT=1 constants.
REQ-030 One sub-module: even_parity, instantiated once, combinational, fed from the holding register; the arbiter and FSM stay in parity_tx_arb.
REQ-031 tx_out, tx_busy and frame_done are registered outputs; the readies are combinational from state, the valids and last_grant.

Verification
REQ-032 Reset, then req0 sends 4'b1011 -> tx_out sequence 0,1,1,0,1,1,1 over 7 cycles; frame_done in cycle 7; tx_src=0.
REQ-033 req1 sends 4'b1100 -> tx_out sequence 0,0,0,1,1,0,1; parity bit=0; tx_src=1.
REQ-034 Both valid continuously with GAP_CYCLES=1 -> grants alternate 0,1,0,1; a new start bit begins every 9 cycles; readies are never both high.
REQ-035 rst asserted during the data[2] cycle -> next cycle state=IDLE, tx_out=1, tx_busy=0, no frame_done; the following frame is correct.
REQ-036 Exhaustive: all 16 nibbles from req0 -> data bits plus parity bit contain an even number of ones in every frame; data changed one cycle after the handshake does not alter the frame.
REQ-037 GAP_CYCLES=0 with continuous valid -> back-to-back frames with one IDLE cycle between the stop bit and the next start bit (8-cycle period).
